// File: rtl/bram_poly_streamer_pkg.sv
// Shared types and constants for the coefficient BRAM read streamer.
package bram_poly_streamer_pkg;

    localparam int DRAM_W      = 32;
    localparam int ADDR_W      = 12;
    localparam int BRAM_RD_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/bram_poly_streamer_if.sv
// Command, BRAM port and output stream of the streamer; master is the streamer's own view.
interface bram_poly_streamer_if #(
    parameter int DRAM_W = 32,
    parameter int ADDR_W = 12
);
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_adr;
    logic [DRAM_W-1:0] bram_dout;
    logic              valid;
    logic              ready;
    logic [DRAM_W-1:0] data;
    logic              last;

    modport master (
        input  start, base, len, bram_dout, ready,
        output busy, done, bram_en, bram_we, bram_adr, valid, data, last
    );

    modport slave (
        output start, base, len, bram_dout, ready,
        input  busy, done, bram_en, bram_we, bram_adr, valid, data, last
    );
endinterface

// File: rtl/bram_poly_streamer_fifo2.sv
// Two-entry register FIFO; slot0 is always the head so dout only moves on a pop.
module stream_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             iSYS_CLK,
    input  logic             iSYS_RSTn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       occ,
    output logic             empty
);
    logic [WIDTH-1:0] slot0_q;
    logic [WIDTH-1:0] slot1_q;
    logic [1:0]       occ_q;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (occ_q != 2'd0);
    assign do_push = push && ((occ_q != 2'd2) || do_pop);

    // NOTE: the storage slots are reset too; they are two flops, not a RAM, and this keeps dout at 0 out of reset.
    always_ff @(posedge iSYS_CLK or negedge iSYS_RSTn) begin
        if (!iSYS_RSTn) begin
            slot0_q <= '0;
            slot1_q <= '0;
            occ_q   <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ_q == 2'd0) slot0_q <= din;
                    else               slot1_q <= din;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    occ_q   <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        slot0_q <= din;
                    end else begin
                        slot0_q <= slot1_q;
                        slot1_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = slot0_q;
    assign occ   = occ_q;
    assign empty = (occ_q == 2'd0);
endmodule

// File: rtl/bram_poly_streamer.sv
// Reads len words from the coefficient BRAM starting at base and streams them out
// with valid/ready backpressure, hiding the 1-cycle BRAM read latency.
module bram_poly_streamer
    import bram_poly_streamer_pkg::*;
#(
    parameter int PRM_DRAM = DRAM_W,
    parameter int PRM_ADDR = ADDR_W
) (
    input  logic                 iSYS_CLK,
    input  logic                 iSYS_RSTn,
    bram_poly_streamer_if.master io
);
    state_e                 state_q;
    state_e                 state_d;
    logic [PRM_ADDR-1:0]    base_q;
    logic [PRM_ADDR:0]      len_q;
    logic [PRM_ADDR:0]      issued_q;
    logic [PRM_ADDR:0]      accepted_q;
    logic [BRAM_RD_LAT-1:0] inflight_q;
    logic                   last_rd_q;
    logic                   done_q;

    logic                   start_ok;
    logic                   start_zero;
    logic                   issue;
    logic                   last_issue;
    logic                   pop;
    logic                   last_pop;
    logic [2:0]             pending;
    logic                   fifo_empty;
    logic [1:0]             fifo_occ;
    logic [PRM_DRAM:0]      fifo_dout;

    assign start_ok   = (state_q == ST_IDLE) && io.start && (io.len != '0);
    assign start_zero = (state_q == ST_IDLE) && io.start && (io.len == '0);
    assign pop        = !fifo_empty && io.ready;

    // Words already committed to the FIFO once this cycle's pop is taken out; at most 2 may exist.
    assign pending    = {1'b0, fifo_occ} + {2'b0, inflight_q[BRAM_RD_LAT-1]} - {2'b0, pop};
    assign issue      = (state_q == ST_RUN) && (issued_q < len_q) && (pending < 3'd2);
    assign last_issue = issue && (issued_q == len_q - 1'b1);
    assign last_pop   = pop && (accepted_q == len_q - 1'b1);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok)   state_d = ST_RUN;
            ST_RUN:   if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (last_pop)   state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iSYS_CLK or negedge iSYS_RSTn) begin
        if (!iSYS_RSTn) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iSYS_CLK or negedge iSYS_RSTn) begin
        if (!iSYS_RSTn) begin
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= '0;
            last_rd_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q               <= start_zero || ((state_q == ST_DRAIN) && last_pop);
            inflight_q[0]        <= issue;
            last_rd_q            <= last_issue;
            if (start_ok) begin
                base_q     <= io.base;
                len_q      <= io.len;
                issued_q   <= '0;
                accepted_q <= '0;
            end else begin
                if (issue) issued_q   <= issued_q + 1'b1;
                if (pop)   accepted_q <= accepted_q + 1'b1;
            end
        end
    end

    // The read data is pushed only on the cycle a read is known to be landing.
    stream_fifo2 #(
        .WIDTH (PRM_DRAM + 1)
    ) u_fifo (
        .iSYS_CLK  (iSYS_CLK),
        .iSYS_RSTn (iSYS_RSTn),
        .push      (inflight_q[BRAM_RD_LAT-1]),
        .din       ({last_rd_q, io.bram_dout}),
        .pop       (pop),
        .dout      (fifo_dout),
        .occ       (fifo_occ),
        .empty     (fifo_empty)
    );

    assign io.busy     = (state_q != ST_IDLE);
    assign io.done     = done_q;
    assign io.bram_en  = issue;
    assign io.bram_we  = 1'b0;
    assign io.bram_adr = base_q + issued_q[PRM_ADDR-1:0];
    assign io.valid    = !fifo_empty;
    assign io.data     = fifo_dout[PRM_DRAM-1:0];
    assign io.last     = !fifo_empty && fifo_dout[PRM_DRAM];
endmodule

// File: tb/tb_bram_poly_streamer.sv
// Randomized bench for bram_poly_streamer: a BRAM model plus a per-transfer expected-word sequence.
module tb_bram_poly_streamer;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [31:0] mem [4096];

    bram_poly_streamer_if #(.DRAM_W(32), .ADDR_W(12)) bus ();

    bram_poly_streamer dut (
        .iSYS_CLK  (clk),
        .iSYS_RSTn (rst_n),
        .io        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM with 1-cycle read latency; garbage whenever the port was not enabled.
    always @(posedge clk) begin
        if (bus.bram_en) bus.bram_dout <= mem[bus.bram_adr];
        else             bus.bram_dout <= $urandom();
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: ready always high; 1: random ready; 2: random with a 10-cycle low stretch
    task automatic run_xfer(input logic [11:0] b, input logic [12:0] l, input int mode, input bit poke);
        int n_reads = 0;
        int n_beats = 0;
        int first_en = -1;
        int first_valid = -1;
        int last_beat_c = -1;
        int done_c = -1;
        int budget = 4 * int'(l) + 60;
        bit held = 1'b0;
        bit pop;
        logic [31:0] held_data = '0;
        logic        held_last = 1'b0;

        @(negedge clk);
        bus.start = 1'b1;
        bus.base  = b;
        bus.len   = l;
        bus.ready = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            case (mode)
                0:       bus.ready = 1'b1;
                2:       bus.ready = (c >= 3 && c < 13) ? 1'b0 : 1'($urandom_range(0, 1));
                default: bus.ready = 1'($urandom_range(0, 1));
            endcase
            if (poke && bus.busy && $urandom_range(0, 3) == 0) begin
                bus.start = 1'b1;
                bus.base  = 12'($urandom());
                bus.len   = 13'($urandom_range(0, 100));
            end else begin
                bus.start = 1'b0;
            end
            #1;
            pop = bus.valid && bus.ready;
            check("bram_we", bus.bram_we, 0);
            if (bus.bram_en) begin
                if (first_en < 0) first_en = c;
                check("rd_addr", bus.bram_adr, (int'(b) + n_reads) % 4096);
                check("rd_outstanding", ((n_reads + 1) - (n_beats + int'(pop))) <= 2, 1);
                n_reads++;
                check("rd_overrun", n_reads <= int'(l), 1);
            end
            if (bus.valid) begin
                if (first_valid < 0) first_valid = c;
                if (held) begin
                    check("hold_data", bus.data, held_data);
                    check("hold_last", bus.last, held_last);
                end
                if (bus.ready) begin
                    check("beat_data", bus.data, mem[(int'(b) + n_beats) % 4096]);
                    check("beat_last", bus.last, n_beats == int'(l) - 1);
                    n_beats++;
                    last_beat_c = c;
                end
            end
            held      = bus.valid && !bus.ready;
            held_data = bus.data;
            held_last = bus.last;
            if (bus.done) begin
                done_c = c;
                check("busy_at_done", bus.busy, 0);
                break;
            end
            check("busy_during", bus.busy, l != 0);
        end
        bus.start = 1'b0;
        check("done_seen", done_c > 0, 1);
        check("beats", n_beats, l);
        check("reads", n_reads, l);
        if (l == 0) begin
            check("zero_len_done_cycle", done_c, 1);
            check("zero_len_no_read", first_en < 0, 1);
            check("zero_len_no_valid", first_valid < 0, 1);
        end else if (done_c > 0) begin
            check("done_after_last", done_c, last_beat_c + 1);
            check("first_read_cycle", first_en, 1);
            check("read_to_valid", first_valid - first_en, 2);
            if (mode == 0) check("throughput", last_beat_c - first_valid, int'(l) - 1);
        end
        for (int q = 0; q < 3; q++) begin
            @(negedge clk);
            bus.ready = 1'($urandom_range(0, 1));
            #1;
            check("quiet_done",  bus.done, 0);
            check("quiet_valid", bus.valid, 0);
            check("quiet_en",    bus.bram_en, 0);
            check("quiet_busy",  bus.busy, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_done"},  bus.done, 0);
        check({tag, "_en"},    bus.bram_en, 0);
        check({tag, "_valid"}, bus.valid, 0);
        check({tag, "_last"},  bus.last, 0);
        check({tag, "_adr"},   bus.bram_adr, 0);
        check({tag, "_data"},  bus.data, 0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.base  = '0;
        bus.len   = '0;
        bus.ready = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom();

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        run_xfer(12'h010, 13'd4, 0, 1'b0);
        run_xfer(12'hFFE, 13'd4, 0, 1'b0);
        run_xfer(12'($urandom()), 13'd8, 2, 1'b0);
        run_xfer(12'($urandom()), 13'd0, 0, 1'b0);
        run_xfer(12'($urandom()), 13'd16, 1, 1'b1);
        repeat (8) run_xfer(12'($urandom()), 13'($urandom_range(1, 40)),
                            $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        run_xfer(12'hF00, 13'd4096, 1, 1'b0);

        // Reset asserted mid-cycle while the third beat of a len=8 transfer is presented.
        @(negedge clk);
        bus.start = 1'b1;
        bus.base  = 12'h123;
        bus.len   = 13'd8;
        bus.ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("pre_reset_valid", bus.valid, 1);
        check("pre_reset_data", bus.data, mem[12'h125]);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer(12'($urandom()), 13'd2, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
